// File: rtl/fifo_ctrl_if.sv
`default_nettype none
// ==========================================================================
// fifo_ctrl_if : push/pop valid-ready handshake bundle for fifo_ctrl
// Revision 1.0 : initial release
// ==========================================================================
interface fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ==========================================================================
// fifo_ctrl : FIFO controller over a 1-cycle-latency dual-port RAM, 2-word output buffer
// Revision 1.0 : initial release
// ==========================================================================
module fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  flush,
  fifo_ctrl_if.slave                 bus,
  output logic [ADDR_WIDTH-1:0]      ram_address_0,
  output logic                       ram_chip_enable_0,
  output logic                       ram_write_read_0,
  output logic [DATA_WIDTH-1:0]      ram_data_0,
  output logic [ADDR_WIDTH-1:0]      ram_address_1,
  output logic                       ram_chip_enable_1,
  output logic                       ram_write_read_1,
  input  wire logic [DATA_WIDTH-1:0] ram_data_1,
  output logic [ADDR_WIDTH+1:0]      count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int                  RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int                  CW        = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] c_depth   = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [CW-1:0]       c_afull   = CW'(AFULL_LVL);
  localparam logic [CW-1:0]       c_aempty  = CW'(AEMPTY_LVL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            ob_cnt_q, ob_cnt_d;
  logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
  logic [DATA_WIDTH-1:0] ob1_q, ob1_d;

  logic                  wr_ready;
  logic                  rd_valid;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            ob_level;

  always_comb begin
    wr_ready = (mem_cnt_q != c_depth);
    rd_valid = (ob_cnt_q != 2'd0);
    // rst gates the strobes so both RAM enables drop the instant reset rises
    push     = bus.wr_valid & wr_ready & ~flush & ~rst;
    pop      = rd_valid & bus.rd_ready & ~flush & ~rst;
    ob_level = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue    = ~flush & ~rst & (mem_cnt_q != '0) & (ob_level < 3'd2);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(issue);
    mem_cnt_d  = mem_cnt_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(issue);
    inflight_d = issue;
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;
    ob_cnt_d   = ob_cnt_q;
    if (pop) begin
      ob0_d    = ob1_q;
      ob_cnt_d = ob_cnt_q - 2'd1;
    end
    // RAM word lands behind whatever survives this cycle's pop
    if (inflight_q) begin
      if (ob_cnt_d == 2'd0) begin
        ob0_d = ram_data_1;
      end else begin
        ob1_d = ram_data_1;
      end
      ob_cnt_d = ob_cnt_d + 2'd1;
    end
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      mem_cnt_d  = '0;
      inflight_d = 1'b0;
      ob_cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= 2'd0;
      ob0_q      <= '0;
      ob1_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
    end
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.rd_valid      = rd_valid;
  assign bus.rd_data       = ob0_q;

  assign ram_address_0     = wr_ptr_q;
  assign ram_chip_enable_0 = push;
  assign ram_write_read_0  = push;
  assign ram_data_0        = bus.wr_data;
  assign ram_address_1     = rd_ptr_q;
  assign ram_chip_enable_1 = issue;
  assign ram_write_read_1  = 1'b0;

  assign count        = CW'(mem_cnt_q) + CW'(inflight_q) + CW'(ob_cnt_q);
  assign full         = (mem_cnt_q == c_depth);
  assign empty        = (count == '0);
  assign almost_full  = (count >= c_afull);
  assign almost_empty = (count <= c_aempty);

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_fifo_ctrl : scoreboard bench for fifo_ctrl (depth 4, capacity 6)
// Revision 1.0 : initial release
// ==========================================================================
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] ram_address_0, ram_address_1;
  logic       ram_chip_enable_0, ram_write_read_0;
  logic       ram_chip_enable_1, ram_write_read_1;
  logic [7:0] ram_data_0, ram_data_1;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty;

  fifo_ctrl_if #(.DATA_WIDTH(8)) bus ();

  fifo_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_LVL(4), .AEMPTY_LVL(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .ram_address_0(ram_address_0), .ram_chip_enable_0(ram_chip_enable_0),
    .ram_write_read_0(ram_write_read_0), .ram_data_0(ram_data_0),
    .ram_address_1(ram_address_1), .ram_chip_enable_1(ram_chip_enable_1),
    .ram_write_read_1(ram_write_read_1), .ram_data_1(ram_data_1),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after the read enable
  logic [7:0] ram [4];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (ram_chip_enable_0 && ram_write_read_0) ram[ram_address_0] <= ram_data_0;
    if (ram_chip_enable_1) ram_q <= ram[ram_address_1];
  end
  assign ram_data_1 = ram_q;

  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle of stimulus; returns at the negedge of that cycle
  task automatic cyc(input bit wv, input logic [7:0] wd, input bit rr, input bit fl);
    @(posedge clk);
    #1;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    flush        = fl;
    @(negedge clk);
    if (!rst) begin
      if (flush) exp_q.delete();
      else if (bus.wr_valid && bus.wr_ready) exp_q.push_back(bus.wr_data);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || count != 4'd0) && n < 50) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_aempty"}, 32'(almost_empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_afull"}, 32'(almost_full), 32'd0);
    chk({tag, "_ce0"}, 32'(ram_chip_enable_0), 32'd0);
    chk({tag, "_ce1"}, 32'(ram_chip_enable_1), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted read and tracks occupancy
  int         held = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      held       = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("stall_rd_data", 32'(bus.rd_data), 32'(prev_data));
      end
      chk("count", 32'(count), 32'(held));
      chk("empty", 32'(empty), 32'(held == 0));
      chk("almost_full", 32'(almost_full), 32'(held >= 4));
      chk("almost_empty", 32'(almost_empty), 32'(held <= 1));
      if (flush) begin
        held = 0;
      end else begin
        if (bus.rd_valid && bus.rd_ready) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL pop_order: got pop of 0x%0h, expected no word pending", bus.rd_data);
          end else begin
            chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
          end
          held--;
        end
        if (bus.wr_valid && bus.wr_ready) held++;
      end
      prev_stall = bus.rd_valid && !bus.rd_ready && !flush;
      prev_data  = bus.rd_data;
    end
  end

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hFF;
    bus.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.wr_valid = 1'b0;
    @(negedge clk);

    // First-word latency
    cyc(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("lat_c0_rd_valid", 32'(bus.rd_valid), 32'd0);
    for (int k = 1; k < 3; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("lat_early_rd_valid", 32'(bus.rd_valid), 32'd0);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lat_c3_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("lat_c3_rd_data", 32'(bus.rd_data), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lat_c4_empty", 32'(empty), 32'd1);

    // Fill to capacity with consumer stalled
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1, 8'(k + 1), 1'b0, 1'b0);
      chk("fill_wr_ready", 32'(bus.wr_ready), 32'(k < 6));
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd6);
    drain();

    // Streaming: one word per cycle, no bubbles, pointers wrap four times
    for (int k = 0; k < 20; k++) begin
      cyc(k < 16, 8'(k), 1'b1, 1'b0);
      if (k < 16) chk("stream_wr_ready", 32'(bus.wr_ready), 32'd1);
      chk("stream_rd_valid", 32'(bus.rd_valid), 32'(k >= 3 && k <= 18));
    end
    drain();

    // Consumer toggling while streaming
    for (int k = 0; k < 16; k++) cyc(k < 10, 8'(8'h40 + k), (k % 2) == 0, 1'b0);
    drain();

    // Flush with count=5 and a read in flight
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h50 + k), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("flush_setup_issue", 32'(ram_chip_enable_1), 32'd1);
    cyc(1'b1, 8'h66, 1'b1, 1'b1);
    chk("flush_pre_count", 32'(count), 32'd5);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_post_count", 32'(count), 32'd0);
    chk("flush_post_empty", 32'(empty), 32'd1);
    chk("flush_post_rd_valid", 32'(bus.rd_valid), 32'd0);
    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    drain();

    // Asynchronous reset mid-stream, between clock edges
    for (int k = 0; k < 6; k++) cyc(1'b1, 8'(8'h70 + k), 1'b1, 1'b0);
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h7F;
    bus.rd_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    cyc(1'b1, 8'h9A, 1'b1, 1'b0);
    drain();

    // Random traffic with occasional flush
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 49) == 0);
    end
    drain();

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
